// File: rtl/rv_hazard_ctrl_pkg.sv
// Shared types and constants for the rv_hazard_ctrl pipeline hazard controller.
package rv_hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam logic [1:0] FWD_MEM  = 2'b11;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      wen;
        logic                      load;
    } hz_stage_t;

endpackage

// File: rtl/rv_hazard_fwd_sel.sv
// Per-operand forward select and load-use detect from the E and M tracking entries.
module rv_hazard_fwd_sel
    import rv_hazard_ctrl_pkg::*;
#(
    parameter int unsigned ZERO_REG = 0
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_i,
    input  logic                      rs_used_i,
    input  logic                      valid_d_i,
    input  logic                      e_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] e_rd_i,
    input  logic                      e_wen_i,
    input  logic                      e_load_i,
    input  logic                      m_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] m_rd_i,
    input  logic                      m_wen_i,
    output logic [1:0]                sel_o,
    output logic                      load_haz_o
);

    logic rs_live;
    logic hit_e;
    logic hit_m;

    assign rs_live = valid_d_i & rs_used_i & (rs_i != REG_ADDR_WIDTH'(ZERO_REG));
    assign hit_e   = rs_live & e_valid_i & e_wen_i & (e_rd_i == rs_i);
    assign hit_m   = rs_live & m_valid_i & m_wen_i & (m_rd_i == rs_i);

    assign load_haz_o = hit_e & e_load_i;

    // Youngest producer wins; a load in E cannot forward and is handled by the stall.
    always_comb begin
        sel_o = FWD_NONE;
        if (hit_e && !e_load_i) begin
            sel_o = FWD_MEM;
        end else if (hit_m) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/rv_hazard_ctrl.sv
// 5-stage RV hazard controller: forwarding selects, load-use stall, flush and freeze.
// Optional stall/flush event counters are built when RV_HAZARD_STAT_EN is defined.
module rv_hazard_ctrl
    import rv_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_WIDTH,
    parameter int unsigned ZERO_REG   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  validD,
    input  logic [REG_ADDR_W-1:0] rs1_addrD,
    input  logic [REG_ADDR_W-1:0] rs2_addrD,
    input  logic                  rs1_usedD,
    input  logic                  rs2_usedD,
    input  logic [REG_ADDR_W-1:0] rd_addrD,
    input  logic                  reg_wenD,
    input  logic                  mem_renD,
    input  logic                  branch_takenE,
    input  logic                  mem_waitM,
    output logic [1:0]            forward_rs1E,
    output logic [1:0]            forward_rs2E,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  stallE,
    output logic                  stallM,
    output logic                  flushD,
    output logic                  flushE
`ifdef RV_HAZARD_STAT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    hz_stage_t e_q, e_d;
    hz_stage_t m_q, m_d;
    hz_stage_t w_q, w_d;
    logic [1:0] fwd1_q, fwd1_d;
    logic [1:0] fwd2_q, fwd2_d;

    logic [1:0] sel1, sel2;
    logic       lh1, lh2;
    logic       freeze, flush, load_use;

    rv_hazard_fwd_sel #(
        .ZERO_REG (ZERO_REG)
    ) u_sel_rs1 (
        .rs_i       (rs1_addrD),
        .rs_used_i  (rs1_usedD),
        .valid_d_i  (validD),
        .e_valid_i  (e_q.valid),
        .e_rd_i     (e_q.rd),
        .e_wen_i    (e_q.wen),
        .e_load_i   (e_q.load),
        .m_valid_i  (m_q.valid),
        .m_rd_i     (m_q.rd),
        .m_wen_i    (m_q.wen),
        .sel_o      (sel1),
        .load_haz_o (lh1)
    );

    rv_hazard_fwd_sel #(
        .ZERO_REG (ZERO_REG)
    ) u_sel_rs2 (
        .rs_i       (rs2_addrD),
        .rs_used_i  (rs2_usedD),
        .valid_d_i  (validD),
        .e_valid_i  (e_q.valid),
        .e_rd_i     (e_q.rd),
        .e_wen_i    (e_q.wen),
        .e_load_i   (e_q.load),
        .m_valid_i  (m_q.valid),
        .m_rd_i     (m_q.rd),
        .m_wen_i    (m_q.wen),
        .sel_o      (sel2),
        .load_haz_o (lh2)
    );

    // Gated by rst_n so controls read 0 while reset is held, whatever the inputs do.
    always_comb begin
        freeze   = rst_n & mem_waitM;
        flush    = rst_n & branch_takenE & ~mem_waitM;
        load_use = rst_n & (lh1 | lh2) & ~mem_waitM & ~branch_takenE;

        stallF = freeze | load_use;
        stallD = freeze | load_use;
        stallE = freeze;
        stallM = freeze;
        flushD = flush;
        flushE = flush | load_use;
    end

    always_comb begin
        e_d    = '{valid: validD, rd: rd_addrD, wen: reg_wenD, load: mem_renD};
        m_d    = e_q;
        w_d    = m_q;
        fwd1_d = sel1;
        fwd2_d = sel2;
        if (freeze) begin
            e_d    = e_q;
            m_d    = m_q;
            w_d    = w_q;
            fwd1_d = fwd1_q;
            fwd2_d = fwd2_q;
        end else if (flush || load_use) begin
            e_d.valid = 1'b0;
            fwd1_d    = FWD_NONE;
            fwd2_d    = FWD_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            fwd1_q <= FWD_NONE;
            fwd2_q <= FWD_NONE;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            fwd1_q <= fwd1_d;
            fwd2_q <= fwd2_d;
        end
    end

    assign forward_rs1E = fwd1_q;
    assign forward_rs2E = fwd2_q;

`ifdef RV_HAZARD_STAT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (load_use) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush)    flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Self-checking bench for rv_hazard_ctrl: directed scenarios plus a randomized run
// against an in-bench pipeline occupancy model.
module tb_rv_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       validD, rs1_usedD, rs2_usedD, reg_wenD, mem_renD;
    logic [4:0] rs1_addrD, rs2_addrD, rd_addrD;
    logic       branch_takenE, mem_waitM;
    logic [1:0] forward_rs1E, forward_rs2E;
    logic       stallF, stallD, stallE, stallM, flushD, flushE;
`ifdef RV_HAZARD_STAT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_hazard_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .validD        (validD),
        .rs1_addrD     (rs1_addrD),
        .rs2_addrD     (rs2_addrD),
        .rs1_usedD     (rs1_usedD),
        .rs2_usedD     (rs2_usedD),
        .rd_addrD      (rd_addrD),
        .reg_wenD      (reg_wenD),
        .mem_renD      (mem_renD),
        .branch_takenE (branch_takenE),
        .mem_waitM     (mem_waitM),
        .forward_rs1E  (forward_rs1E),
        .forward_rs2E  (forward_rs2E),
        .stallF        (stallF),
        .stallD        (stallD),
        .stallE        (stallE),
        .stallM        (stallM),
        .flushD        (flushD),
        .flushE        (flushE)
`ifdef RV_HAZARD_STAT_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    // Reference model: list of in-flight producers, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit v;
        int rd;
        bit wen;
        bit ld;
    } ent_t;

    ent_t       pipe[3];
    logic [1:0] mf1, mf2;
    int         m_stalls, m_flushes;

    function automatic bit writes(ent_t e, int rs, bit used, bit vd);
        return vd && used && rs != 0 && e.v && e.wen && e.rd == rs;
    endfunction

    function automatic logic [1:0] pick(int rs, bit used, bit vd);
        if (writes(pipe[0], rs, used, vd) && !pipe[0].ld) return 2'b11;
        if (writes(pipe[1], rs, used, vd)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [5:0] ctrl();
        return {stallF, stallD, stallE, stallM, flushD, flushE};
    endfunction

    task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                         input int rd, input bit wen, input bit ld, input bit br, input bit mw);
        validD        = v;
        rs1_addrD     = 5'(r1);
        rs1_usedD     = u1;
        rs2_addrD     = 5'(r2);
        rs2_usedD     = u2;
        rd_addrD      = 5'(rd);
        reg_wenD      = wen;
        mem_renD      = ld;
        branch_takenE = br;
        mem_waitM     = mw;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle();
        #2 rst_n = 1'b0;
        drive(1, 1, 1, 2, 1, 3, 1, 1, 1, 1);
        #1;
        checks++;
        if (ctrl() !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b", ctrl(), 6'b0);
        end
        step();
        checks++;
        if ({forward_rs1E, forward_rs2E} !== 4'b0) begin
            errors++;
            $display("FAIL reset_fwd: got %b expected 0000", {forward_rs1E, forward_rs2E});
        end
`ifdef RV_HAZARD_STAT_EN
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
        #1;
        checks++;
        if (ctrl() !== 6'b0) begin
            errors++;
            $display("FAIL reset_empty_ctrl: got %b expected %b", ctrl(), 6'b0);
        end
    endtask

    task automatic test_fwd_mem();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        step();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        #1;
        checks++;
        if (ctrl() !== 6'b0) begin
            errors++;
            $display("FAIL fwd_mem_ctrl: got %b expected %b", ctrl(), 6'b0);
        end
        step();
        checks++;
        if ({forward_rs1E, forward_rs2E} !== 4'b1100) begin
            errors++;
            $display("FAIL fwd_mem: got %b expected 1100", {forward_rs1E, forward_rs2E});
        end
    endtask

    task automatic test_fwd_wb();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        step();
        drive(1, 6, 0, 5, 1, 7, 1, 0, 0, 0);
        step();
        checks++;
        if ({forward_rs1E, forward_rs2E} !== 4'b0010) begin
            errors++;
            $display("FAIL fwd_wb: got %b expected 0010", {forward_rs1E, forward_rs2E});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        step();
        drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
        #1;
        checks++;
        if (ctrl() !== 6'b110001) begin
            errors++;
            $display("FAIL load_use_ctrl: got %b expected %b", ctrl(), 6'b110001);
        end
        step();
        checks++;
        if (forward_rs1E !== 2'b00) begin
            errors++;
            $display("FAIL load_use_bubble: got %b expected 00", forward_rs1E);
        end
        checks++;
        if (ctrl() !== 6'b0) begin
            errors++;
            $display("FAIL load_use_release: got %b expected %b", ctrl(), 6'b0);
        end
        step();
        checks++;
        if (forward_rs1E !== 2'b10) begin
            errors++;
            $display("FAIL load_use_wb: got %b expected 10", forward_rs1E);
        end
    endtask

    task automatic test_x0();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step();
        drive(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        #1;
        checks++;
        if (ctrl() !== 6'b0) begin
            errors++;
            $display("FAIL x0_ctrl: got %b expected %b", ctrl(), 6'b0);
        end
        step();
        checks++;
        if ({forward_rs1E, forward_rs2E} !== 4'b0) begin
            errors++;
            $display("FAIL x0_fwd_e: got %b expected 0000", {forward_rs1E, forward_rs2E});
        end
        step();
        checks++;
        if ({forward_rs1E, forward_rs2E} !== 4'b0) begin
            errors++;
            $display("FAIL x0_fwd_m: got %b expected 0000", {forward_rs1E, forward_rs2E});
        end
    endtask

    task automatic test_flush_freeze();
        do_reset();
        drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
        step();
        drive(1, 9, 1, 0, 0, 10, 1, 0, 1, 0);
        #1;
        checks++;
        if (ctrl() !== 6'b000011) begin
            errors++;
            $display("FAIL flush_ctrl: got %b expected %b", ctrl(), 6'b000011);
        end
        step();
        checks++;
        if (forward_rs1E !== 2'b00) begin
            errors++;
            $display("FAIL flush_fwd: got %b expected 00", forward_rs1E);
        end
        drive(1, 9, 1, 0, 0, 10, 1, 0, 0, 0);
        step();
        checks++;
        if (forward_rs1E !== 2'b10) begin
            errors++;
            $display("FAIL flush_then_wb: got %b expected 10", forward_rs1E);
        end
        // Freeze: E holds a consumer of x3, M holds the add x3.
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        step();
        drive(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 11, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctrl() !== 6'b111100) begin
                errors++;
                $display("FAIL freeze_ctrl[%0d]: got %b expected %b", i, ctrl(), 6'b111100);
            end
            step();
            checks++;
            if (forward_rs1E !== 2'b11) begin
                errors++;
                $display("FAIL freeze_hold[%0d]: got %b expected 11", i, forward_rs1E);
            end
        end
        drive(1, 3, 1, 0, 0, 12, 1, 0, 0, 0);
        step();
        checks++;
        if (forward_rs1E !== 2'b10) begin
            errors++;
            $display("FAIL freeze_tracking: got %b expected 10", forward_rs1E);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        step();
        drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
        #1;
        checks++;
        if (ctrl() !== 6'b110001) begin
            errors++;
            $display("FAIL mid_stall_pre: got %b expected %b", ctrl(), 6'b110001);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ctrl(), forward_rs1E, forward_rs2E} !== 10'b0) begin
            errors++;
            $display("FAIL mid_stall_reset: got %b expected 0",
                     {ctrl(), forward_rs1E, forward_rs2E});
        end
        mem_waitM = 1'b1;
        #1;
        checks++;
        if (ctrl() !== 6'b0) begin
            errors++;
            $display("FAIL mid_freeze_reset: got %b expected %b", ctrl(), 6'b0);
        end
`ifdef RV_HAZARD_STAT_EN
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
        #1;
        checks++;
        if (ctrl() !== 6'b0) begin
            errors++;
            $display("FAIL post_reset_ctrl: got %b expected %b", ctrl(), 6'b0);
        end
        step();
        checks++;
        if (forward_rs1E !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_fwd: got %b expected 00", forward_rs1E);
        end
    endtask

    task automatic test_random();
        bit         v, u1, u2, wen, ld, br, mw, lh, fr, fl, st;
        int         r1, r2, rd;
        logic [1:0] s1, s2;
        logic [5:0] exp_ctrl;
        do_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{v: 0, rd: 0, wen: 0, ld: 0};
        mf1 = 2'b00;
        mf2 = 2'b00;
        m_stalls = 0;
        m_flushes = 0;
        for (int n = 0; n < 500; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            r1  = $urandom_range(0, 7);
            r2  = $urandom_range(0, 7);
            rd  = $urandom_range(0, 7);
            u1  = $urandom_range(0, 3) != 0;
            u2  = $urandom_range(0, 1) != 0;
            wen = $urandom_range(0, 3) != 0;
            ld  = wen && ($urandom_range(0, 2) == 0);
            br  = $urandom_range(0, 9) == 0;
            mw  = $urandom_range(0, 7) == 0;
            drive(v, r1, u1, r2, u2, rd, wen, ld, br, mw);
            #1;
            lh = pipe[0].ld && (writes(pipe[0], r1, u1, v) || writes(pipe[0], r2, u2, v));
            fr = mw;
            fl = br && !mw;
            st = lh && !mw && !br;
            exp_ctrl = {fr || st, fr || st, fr, fr, fl, fl || st};
            checks++;
            if (ctrl() !== exp_ctrl) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got %b expected %b", n, ctrl(), exp_ctrl);
            end
            if (!fr) begin
                s1 = pick(r1, u1, v);
                s2 = pick(r2, u2, v);
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                if (fl || st) begin
                    pipe[0] = '{v: 0, rd: 0, wen: 0, ld: 0};
                    mf1 = 2'b00;
                    mf2 = 2'b00;
                end else begin
                    pipe[0] = '{v: v, rd: rd, wen: wen, ld: ld};
                    mf1 = s1;
                    mf2 = s2;
                end
                if (st) m_stalls++;
                if (fl) m_flushes++;
            end
            step();
            checks++;
            if ({forward_rs1E, forward_rs2E} !== {mf1, mf2}) begin
                errors++;
                $display("FAIL rand_fwd[%0d]: got %b expected %b", n,
                         {forward_rs1E, forward_rs2E}, {mf1, mf2});
            end
        end
`ifdef RV_HAZARD_STAT_EN
        checks++;
        if (stall_cnt !== 32'(m_stalls) || flush_cnt !== 32'(m_flushes)) begin
            errors++;
            $display("FAIL rand_cnt: got %0d/%0d expected %0d/%0d",
                     stall_cnt, flush_cnt, m_stalls, m_flushes);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fwd_mem();
        test_fwd_wb();
        test_load_use();
        test_x0();
        test_flush_freeze();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
